// File: rtl/tile_scroll_gen.sv
// Two-axis scrolling tile pattern generator: fixed-point per-axis scroll accumulators,
// frame-shadowed tile mode, programmable colours, one-clock registered pixel output.
module tile_scroll_gen #(
  parameter int unsigned TILE_LOG2 = 5,
  parameter int unsigned FRAC_BITS = 4,
  parameter int unsigned STEP_W    = 12,
  parameter int unsigned COLOR_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pattern_enable,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               active,
  input  logic               next_frame,
  input  logic [STEP_W-1:0]  step_x,
  input  logic [STEP_W-1:0]  step_y,
  input  logic               dir_x,
  input  logic               dir_y,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] color_a,
  input  logic [COLOR_W-1:0] color_b,
  output logic [COLOR_W-1:0] rgb,
  output logic [9:0]         off_x,
  output logic [9:0]         off_y
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned ACC_W   = COORD_W + FRAC_BITS;

  localparam logic [1:0] MODE_CHECKER = 2'd0;
  localparam logic [1:0] MODE_VSTRIPE = 2'd1;
  localparam logic [1:0] MODE_HSTRIPE = 2'd2;

  logic [ACC_W-1:0]   acc_x_q, acc_x_d;
  logic [ACC_W-1:0]   acc_y_q, acc_y_d;
  logic [1:0]         mode_q, mode_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;

  logic               frame_adv;
  logic [COORD_W-1:0] sx, sy, sxy;
  logic               tile;

  assign frame_adv = pattern_enable & next_frame;

  // Scroll accumulators and mode shadow advance only on an enabled frame boundary.
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    mode_d  = mode_q;
    if (frame_adv) begin
      acc_x_d = dir_x ? (acc_x_q - ACC_W'(step_x)) : (acc_x_q + ACC_W'(step_x));
      acc_y_d = dir_y ? (acc_y_q - ACC_W'(step_y)) : (acc_y_q + ACC_W'(step_y));
      mode_d  = mode;
    end
  end

  assign off_x = acc_x_q[ACC_W-1:FRAC_BITS];
  assign off_y = acc_y_q[ACC_W-1:FRAC_BITS];

  // Scrolled coordinates wrap modulo the 10-bit screen space.
  always_comb begin
    sx  = x + off_x;
    sy  = y + off_y;
    sxy = sx + sy;
    case (mode_q)
      MODE_CHECKER: tile = sx[TILE_LOG2] ^ sy[TILE_LOG2];
      MODE_VSTRIPE: tile = sx[TILE_LOG2];
      MODE_HSTRIPE: tile = sy[TILE_LOG2];
      default:      tile = sxy[TILE_LOG2];
    endcase
    rgb_d = '0;
    if (active) begin
      rgb_d = tile ? color_a : color_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
      mode_q  <= MODE_CHECKER;
      rgb_q   <= '0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      mode_q  <= mode_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_tile_scroll_gen.sv
// Scoreboarded bench for tile_scroll_gen: expected pixels are queued as stimulus is driven
// and checked one clock later; offsets are checked against a fixed-point reference model.
module tb_tile_scroll_gen;

  localparam int unsigned T = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        pattern_enable;
  logic [9:0]  x, y;
  logic        active;
  logic        next_frame;
  logic [11:0] step_x, step_y;
  logic        dir_x, dir_y;
  logic [1:0]  mode;
  logic [5:0]  color_a, color_b;
  logic [5:0]  rgb;
  logic [9:0]  off_x, off_y;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] m_acc_x, m_acc_y;
  logic [1:0]  m_mode;
  logic [5:0]  sb_q[$];

  tile_scroll_gen dut (
    .clk(clk), .rst(rst), .pattern_enable(pattern_enable),
    .x(x), .y(y), .active(active), .next_frame(next_frame),
    .step_x(step_x), .step_y(step_y), .dir_x(dir_x), .dir_y(dir_y),
    .mode(mode), .color_a(color_a), .color_b(color_b),
    .rgb(rgb), .off_x(off_x), .off_y(off_y)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model_rgb();
    logic [9:0] sx, sy, ss;
    logic       t;
    sx = x + m_acc_x[13:4];
    sy = y + m_acc_y[13:4];
    ss = sx + sy;
    case (m_mode)
      2'd0:    t = sx[T] ^ sy[T];
      2'd1:    t = sx[T];
      2'd2:    t = sy[T];
      default: t = ss[T];
    endcase
    if (!active) return 6'h00;
    return t ? color_a : color_b;
  endfunction

  // One clock: queue expected pixel, advance model, then check pixel and offsets.
  task automatic cycle(input string tag);
    logic [5:0] e;
    sb_q.push_back(model_rgb());
    if (pattern_enable && next_frame) begin
      m_mode  = mode;
      m_acc_x = dir_x ? (m_acc_x - 14'(step_x)) : (m_acc_x + 14'(step_x));
      m_acc_y = dir_y ? (m_acc_y - 14'(step_y)) : (m_acc_y + 14'(step_y));
    end
    @(posedge clk); #1;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s rgb: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      if (rgb !== e) begin
        n_fail++;
        $display("FAIL %s rgb: got %h expected %h", tag, rgb, e);
      end
    end
    n_tests++;
    if (off_x !== m_acc_x[13:4] || off_y !== m_acc_y[13:4]) begin
      n_fail++;
      $display("FAIL %s offsets: got %h/%h expected %h/%h", tag, off_x, off_y,
               m_acc_x[13:4], m_acc_y[13:4]);
    end
  endtask

  task automatic pulse(input string tag);
    next_frame = 1'b1;
    cycle(tag);
    next_frame = 1'b0;
  endtask

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  // Asynchronous reset assertion, checked before any clock edge, then released.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    m_acc_x = '0; m_acc_y = '0; m_mode = 2'd0;
    sb_q.delete();
    check_val({tag, "_rgb"}, 10'(rgb), 10'h000);
    check_val({tag, "_offx"}, off_x, 10'h000);
    check_val({tag, "_offy"}, off_y, 10'h000);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode = 2'd0; active = 1'b1; x = 10'd0; y = 10'd0;
    color_a = 6'h3F; color_b = 6'h00;
    do_reset("reset");
    cycle("reset_first_pixel");
    check_val("reset_rgb_b", 10'(rgb), 10'(color_b));
    color_b = 6'h15;
  endtask

  task automatic test_scroll_x();
    step_x = 12'h010; dir_x = 1'b0; pattern_enable = 1'b1;
    repeat (4) pulse("scroll_x_pulse");
    check_val("scroll_x_off", off_x, 10'd4);
    x = 10'd28; y = 10'd0;
    cycle("scroll_x_pixel");
    check_val("scroll_x_rgb_a", 10'(rgb), 10'h03F);
  endtask

  task automatic test_frac_y();
    step_x = 12'h000; step_y = 12'h008; dir_y = 1'b0;
    repeat (3) pulse("frac_y_pulse");
    check_val("frac_y_off1", off_y, 10'd1);
    pulse("frac_y_pulse4");
    check_val("frac_y_off2", off_y, 10'd2);
  endtask

  task automatic test_wrap();
    do_reset("wrap_reset");
    step_x = 12'h010; step_y = 12'h000; dir_x = 1'b1;
    pulse("wrap_down");
    check_val("wrap_off_3ff", off_x, 10'h3FF);
    dir_x = 1'b0;
    pulse("wrap_up");
    check_val("wrap_off_0", off_x, 10'h000);
  endtask

  task automatic test_mode_shadow();
    step_x = 12'h000; step_y = 12'h000;
    mode = 2'd1; x = 10'd32; y = 10'd32;
    cycle("shadow_hold");
    check_val("shadow_still_checker", 10'(rgb), 10'h015);
    pulse("shadow_pulse");
    cycle("shadow_applied");
    check_val("shadow_vstripe_a", 10'(rgb), 10'h03F);
  endtask

  task automatic test_pause_blank();
    step_x = 12'h030; step_y = 12'h018;
    pulse("pause_advance");
    check_val("pause_pre_offx", off_x, 10'd3);
    check_val("pause_pre_offy", off_y, 10'd1);
    pattern_enable = 1'b0;
    repeat (3) pulse("pause_pulse");
    check_val("pause_hold_offx", off_x, 10'd3);
    check_val("pause_hold_offy", off_y, 10'd1);
    active = 1'b0;
    cycle("blank");
    check_val("blank_rgb", 10'(rgb), 10'h000);
    active = 1'b1;
    cycle("paused_draws");
    do_reset("midframe_reset");
    cycle("after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      x = 10'($urandom);
      y = 10'($urandom);
      active = ($urandom_range(0, 7) != 0);
      color_a = 6'($urandom);
      color_b = 6'($urandom);
      mode = 2'($urandom);
      step_x = 12'($urandom);
      step_y = 12'($urandom);
      dir_x = 1'($urandom);
      dir_y = 1'($urandom);
      pattern_enable = ($urandom_range(0, 3) != 0);
      next_frame = ($urandom_range(0, 9) == 0);
      cycle("b2b");
    end
    next_frame = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pattern_enable = 1'b0; x = '0; y = '0; active = 1'b1;
    next_frame = 1'b0; step_x = '0; step_y = '0; dir_x = 1'b0; dir_y = 1'b0;
    mode = 2'd0; color_a = 6'h3F; color_b = 6'h00;
    m_acc_x = '0; m_acc_y = '0; m_mode = 2'd0;
    test_reset();
    test_scroll_x();
    test_frac_y();
    test_wrap();
    test_mode_shadow();
    test_pause_blank();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
